// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit CPU: datapath widths, opcode field
// position and the fetch-stage state encoding.
package cpu_pkg;

    localparam int OPCODE_W   = 3;
    localparam int INSTR_W    = 16;
    localparam int ADDR_W     = 16;
    localparam int OPCODE_MSB = 15;
    localparam int OPCODE_LSB = 13;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DISCARD
    } fetch_state_t;

    function automatic logic [OPCODE_W-1:0] opcode_of(input logic [INSTR_W-1:0] word);
        return word[OPCODE_MSB:OPCODE_LSB];
    endfunction

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, req/ready fetch from instruction memory and a
// one-entry instruction register feeding the control decoder.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000
) (
    input  logic                clk,
    input  logic                rst,
    output logic                imem_req,
    output logic [ADDR_W-1:0]   imem_addr,
    input  logic [INSTR_W-1:0]  imem_rdata,
    input  logic                imem_ready,
    input  logic                stall,
    input  logic                redirect,
    input  logic [ADDR_W-1:0]   redirect_pc,
    output logic                instr_valid,
    output logic [INSTR_W-1:0]  instr,
    output logic [ADDR_W-1:0]   instr_pc,
    output logic [OPCODE_W-1:0] opcode
);

    fetch_state_t        state;
    fetch_state_t        state_next;
    logic [ADDR_W-1:0]   pc;
    logic [ADDR_W-1:0]   pc_next;
    logic [ADDR_W-1:0]   req_addr;
    logic [ADDR_W-1:0]   req_addr_next;
    logic [INSTR_W-1:0]  instr_next;
    logic [ADDR_W-1:0]   instr_pc_next;
    logic                instr_valid_next;
    logic                consume;
    logic                space;
    logic                load;
    logic [ADDR_W-1:0]   load_pc;

    assign consume = instr_valid & ~stall;
    assign space   = ~instr_valid | ~stall;
    assign opcode  = opcode_of(instr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            req_addr    <= '0;
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            req_addr    <= req_addr_next;
            instr       <= instr_next;
            instr_pc    <= instr_pc_next;
            instr_valid <= instr_valid_next;
        end
    end

    // imem_req/imem_addr are decoded from state so an abandoned request
    // disappears the moment reset is asserted.
    always_comb begin
        state_next       = state;
        pc_next          = pc;
        req_addr_next    = req_addr;
        instr_next       = instr;
        instr_pc_next    = instr_pc;
        instr_valid_next = instr_valid & ~consume;
        imem_req         = 1'b0;
        imem_addr        = pc;
        load             = 1'b0;
        load_pc          = pc;

        case (state)
            IDLE: begin
                state_next = ISSUE;
            end
            ISSUE: begin
                imem_req = space & ~redirect;
                if (imem_req && imem_ready) begin
                    load = 1'b1;
                end else if (imem_req) begin
                    req_addr_next = pc;
                    state_next    = WAIT;
                end
            end
            WAIT: begin
                imem_req  = 1'b1;
                imem_addr = req_addr;
                load_pc   = req_addr;
                if (imem_ready) begin
                    load       = 1'b1;
                    state_next = ISSUE;
                end
            end
            DISCARD: begin
                imem_req  = 1'b1;
                imem_addr = req_addr;
                if (imem_ready) begin
                    state_next = ISSUE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // A redirect outranks everything: any returning data is stale, and a
        // request still outstanding must be drained in DISCARD.
        if (redirect) begin
            pc_next          = redirect_pc;
            instr_valid_next = 1'b0;
            if ((state == WAIT || state == DISCARD) && !imem_ready) begin
                state_next = DISCARD;
            end else begin
                state_next = ISSUE;
            end
        end else if (load) begin
            instr_next       = imem_rdata;
            instr_pc_next    = load_pc;
            pc_next          = load_pc + 16'd1;
            instr_valid_next = 1'b1;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: a scoreboard of expected fetch
// addresses is compared against every instruction the decoder consumes.
module tb_instr_fetch;
    import cpu_pkg::*;

    logic                clk;
    logic                rst;
    logic                imem_req;
    logic [ADDR_W-1:0]   imem_addr;
    logic [INSTR_W-1:0]  imem_rdata;
    logic                imem_ready;
    logic                stall;
    logic                redirect;
    logic [ADDR_W-1:0]   redirect_pc;
    logic                instr_valid;
    logic [INSTR_W-1:0]  instr;
    logic [ADDR_W-1:0]   instr_pc;
    logic [OPCODE_W-1:0] opcode;

    logic                mem_hold;
    logic [ADDR_W-1:0]   slow_addr;
    logic [7:0]          slow_waits;
    logic [7:0]          wait_cnt;
    logic [7:0]          need_waits;

    logic [ADDR_W-1:0]   exp_q[$];
    int                  checks;
    int                  passes;

    instr_fetch #(.RESET_PC(16'h0000)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_ready  (imem_ready),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .opcode      (opcode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [INSTR_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
        return a ^ 16'hA000;
    endfunction

    // Memory model: data is a fixed function of address; ready can be held
    // off manually or delayed by a number of wait cycles on one address.
    assign imem_rdata = mem_word(imem_addr);
    assign need_waits = (imem_addr == slow_addr) ? slow_waits : 8'd0;
    assign imem_ready = imem_req && !mem_hold && (wait_cnt >= need_waits);

    always @(posedge clk or posedge rst) begin
        if (rst)
            wait_cnt <= 8'd0;
        else if (!imem_req || imem_ready)
            wait_cnt <= 8'd0;
        else
            wait_cnt <= wait_cnt + 8'd1;
    end

    // Every consumed instruction must be the next expected fetch address.
    always @(negedge clk) begin
        logic [ADDR_W-1:0]  epc;
        logic [INSTR_W-1:0] ew;
        if (!rst && instr_valid && !stall) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("[TB] FAIL sb_unexpected: got instr_pc %h, want no instruction", instr_pc);
            end else begin
                epc = exp_q.pop_front();
                ew  = mem_word(epc);
                checks++;
                if (instr_pc !== epc) $display("[TB] FAIL sb_pc: got %h want %h", instr_pc, epc);
                else passes++;
                checks++;
                if (instr !== ew) $display("[TB] FAIL sb_instr: got %h want %h", instr, ew);
                else passes++;
                checks++;
                if (opcode !== ew[15:13]) $display("[TB] FAIL sb_opcode: got %b want %b", opcode, ew[15:13]);
                else passes++;
            end
        end
    end

    initial begin
        #20000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({imem_req, instr_valid} !== 2'b00) $display("[TB] FAIL reset_flags: got req/valid %b want 00", {imem_req, instr_valid});
        else passes++;
        checks++;
        if (imem_addr !== 16'h0000) $display("[TB] FAIL reset_addr: got %h want 0000", imem_addr);
        else passes++;
        checks++;
        if ({instr, instr_pc, opcode} !== 35'd0) $display("[TB] FAIL reset_ir: got %h/%h/%b want 0", instr, instr_pc, opcode);
        else passes++;
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b0) $display("[TB] FAIL idle_req: got %b want 0", imem_req);
        else passes++;
    endtask

    task automatic test_stream();
        for (int i = 0; i < 4; i++) exp_q.push_back(16'(i));
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            @(negedge clk);
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== 16'(i))
                $display("[TB] FAIL stream_addr: got req %b addr %h want 1 %h", imem_req, imem_addr, 16'(i));
            else passes++;
        end
    endtask

    task automatic test_stall();
        bit found = 0;
        for (int k = 0; k < 8 && !found; k++) begin
            next_cycle();
            if (instr_valid && instr_pc == 16'd4) found = 1;
        end
        checks++;
        if (!found) $display("[TB] FAIL stall_reach: got no valid instr_pc 0004, want it within 8 cycles");
        else passes++;
        stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            if (c > 0) next_cycle();
            @(negedge clk);
            checks++;
            if (instr_valid !== 1'b1 || instr_pc !== 16'd4 || instr !== mem_word(16'd4))
                $display("[TB] FAIL stall_hold: got %b %h %h want 1 0004 %h", instr_valid, instr_pc, instr, mem_word(16'd4));
            else passes++;
            checks++;
            if (imem_req !== 1'b0) $display("[TB] FAIL stall_req: got %b want 0", imem_req);
            else passes++;
        end
        exp_q.push_back(16'd4);
        next_cycle();
        stall = 1'b0;
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 16'd5) $display("[TB] FAIL stall_resume: got %b %h want 1 0005", imem_req, imem_addr);
        else passes++;
    endtask

    task automatic test_wait_states();
        bit found = 0;
        exp_q.push_back(16'd5);
        exp_q.push_back(16'd6);
        exp_q.push_back(16'd7);
        for (int k = 0; k < 6 && !found; k++) begin
            next_cycle();
            @(negedge clk);
            if (imem_req && imem_addr == 16'd7) found = 1;
        end
        checks++;
        if (!found) $display("[TB] FAIL wait_reach: got no request to 0007, want one within 6 cycles");
        else passes++;
        for (int c = 0; c < 2; c++) begin
            next_cycle();
            @(negedge clk);
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== 16'd7 || instr_valid !== 1'b0)
                $display("[TB] FAIL wait_hold: got req %b addr %h valid %b want 1 0007 0", imem_req, imem_addr, instr_valid);
            else passes++;
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 16'd7) $display("[TB] FAIL wait_done: got %b %h want 1 0007", instr_valid, instr_pc);
        else passes++;
        checks++;
        if (imem_addr !== 16'd8) $display("[TB] FAIL wait_next: got %h want 0008", imem_addr);
        else passes++;
    endtask

    task automatic test_redirect_wait();
        exp_q.push_back(16'd8);
        next_cycle();
        mem_hold = 1'b1;
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 16'd9) $display("[TB] FAIL rw_issue: got %b %h want 1 0009", imem_req, imem_addr);
        else passes++;
        next_cycle();
        redirect    = 1'b1;
        redirect_pc = 16'h0040;
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 16'd9) $display("[TB] FAIL rw_redirect_req: got %b %h want 1 0009", imem_req, imem_addr);
        else passes++;
        for (int c = 0; c < 2; c++) begin
            next_cycle();
            redirect = 1'b0;
            if (c == 1) mem_hold = 1'b0;
            @(negedge clk);
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== 16'd9 || instr_valid !== 1'b0)
                $display("[TB] FAIL rw_discard: got req %b addr %h valid %b want 1 0009 0", imem_req, imem_addr, instr_valid);
            else passes++;
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0040 || instr_valid !== 1'b0)
            $display("[TB] FAIL rw_target: got req %b addr %h valid %b want 1 0040 0", imem_req, imem_addr, instr_valid);
        else passes++;
        exp_q.push_back(16'h0040);
        next_cycle();
        @(negedge clk);
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 16'h0040) $display("[TB] FAIL rw_first: got %b %h want 1 0040", instr_valid, instr_pc);
        else passes++;
    endtask

    task automatic test_redirect_ready();
        exp_q.push_back(16'h0041);
        next_cycle();
        mem_hold = 1'b1;
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0042) $display("[TB] FAIL rr_issue: got %b %h want 1 0042", imem_req, imem_addr);
        else passes++;
        next_cycle();
        mem_hold    = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 16'h0080;
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0042) $display("[TB] FAIL rr_wait: got %b %h want 1 0042", imem_req, imem_addr);
        else passes++;
        next_cycle();
        redirect = 1'b0;
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0080 || instr_valid !== 1'b0)
            $display("[TB] FAIL rr_target: got req %b addr %h valid %b want 1 0080 0", imem_req, imem_addr, instr_valid);
        else passes++;
        exp_q.push_back(16'h0080);
        next_cycle();
        @(negedge clk);
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 16'h0080) $display("[TB] FAIL rr_first: got %b %h want 1 0080", instr_valid, instr_pc);
        else passes++;
    endtask

    task automatic test_redirect_stall();
        next_cycle();
        stall       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 16'h00C0;
        @(negedge clk);
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 16'h0081 || imem_req !== 1'b0)
            $display("[TB] FAIL rs_cycle: got valid %b pc %h req %b want 1 0081 0", instr_valid, instr_pc, imem_req);
        else passes++;
        next_cycle();
        stall    = 1'b0;
        redirect = 1'b0;
        @(negedge clk);
        checks++;
        if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'h00C0)
            $display("[TB] FAIL rs_flush: got valid %b req %b addr %h want 0 1 00c0", instr_valid, imem_req, imem_addr);
        else passes++;
        exp_q.push_back(16'h00C0);
        next_cycle();
        @(negedge clk);
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 16'h00C0) $display("[TB] FAIL rs_first: got %b %h want 1 00c0", instr_valid, instr_pc);
        else passes++;
    endtask

    task automatic test_wrap();
        exp_q.push_back(16'h00C1);
        next_cycle();
        redirect    = 1'b1;
        redirect_pc = 16'hFFFF;
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b0) $display("[TB] FAIL wrap_noreq: got %b want 0", imem_req);
        else passes++;
        next_cycle();
        redirect = 1'b0;
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 16'hFFFF) $display("[TB] FAIL wrap_req: got %b %h want 1 ffff", imem_req, imem_addr);
        else passes++;
        exp_q.push_back(16'hFFFF);
        exp_q.push_back(16'h0000);
        next_cycle();
        @(negedge clk);
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 16'hFFFF || imem_addr !== 16'h0000)
            $display("[TB] FAIL wrap_ffff: got valid %b pc %h addr %h want 1 ffff 0000", instr_valid, instr_pc, imem_addr);
        else passes++;
        next_cycle();
        @(negedge clk);
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 16'h0000 || imem_addr !== 16'h0001)
            $display("[TB] FAIL wrap_0000: got valid %b pc %h addr %h want 1 0000 0001", instr_valid, instr_pc, imem_addr);
        else passes++;
    endtask

    task automatic test_reset_mid_wait();
        exp_q.push_back(16'h0001);
        next_cycle();
        mem_hold = 1'b1;
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0002) $display("[TB] FAIL rmw_issue: got %b %h want 1 0002", imem_req, imem_addr);
        else passes++;
        next_cycle();
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0002 || instr_valid !== 1'b0)
            $display("[TB] FAIL rmw_wait: got req %b addr %h valid %b want 1 0002 0", imem_req, imem_addr, instr_valid);
        else passes++;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({imem_req, instr_valid} !== 2'b00 || imem_addr !== 16'h0000)
            $display("[TB] FAIL rmw_req: got req %b valid %b addr %h want 0 0 0000", imem_req, instr_valid, imem_addr);
        else passes++;
        checks++;
        if ({instr, instr_pc, opcode} !== 35'd0) $display("[TB] FAIL rmw_ir: got %h/%h/%b want 0", instr, instr_pc, opcode);
        else passes++;
        repeat (2) @(posedge clk);
        mem_hold = 1'b0;
    endtask

    initial begin
        checks      = 0;
        passes      = 0;
        rst         = 1'b1;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;
        mem_hold    = 1'b0;
        slow_addr   = 16'h0007;
        slow_waits  = 8'd2;

        test_reset();
        test_stream();
        test_stall();
        test_wait_states();
        test_redirect_wait();
        test_redirect_ready();
        test_redirect_stall();
        test_wrap();
        test_reset_mid_wait();

        checks++;
        if (exp_q.size() != 0) $display("[TB] FAIL sb_leftover: got %0d pending, want 0", exp_q.size());
        else passes++;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
